// File: rtl/serial_add_sequencer.sv
// Multi-nibble add/subtract sequencer that time-shares one external 4-bit
// ripple adder slice, processing one nibble per clock from LSB to MSB.
module serial_add_sequencer #(
  parameter int unsigned NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [4*NIBBLES-1:0]   op_a,
  input  logic [4*NIBBLES-1:0]   op_b,
  input  logic                   op_cin,
  input  logic                   op_sub,
  output logic [3:0]             add_a,
  output logic [3:0]             add_b,
  output logic                   add_cin,
  input  logic [3:0]             add_sum,
  input  logic                   add_cout,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [4*NIBBLES-1:0]   result,
  output logic                   cout,
  output logic                   busy
);

  localparam int unsigned    IW   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IW-1:0]  LAST = IW'(NIBBLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t               state_q, state_d;
  logic [4*NIBBLES-1:0] a_q, b_q, res_q;
  logic                 sub_q, carry_q;
  logic [IW-1:0]        idx_q;
  logic [3:0]           a_slice, b_slice;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = RUN;
      RUN:     if (idx_q == LAST) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Select the nibble currently fed to the external slice.
  always_comb begin
    a_slice = '0;
    b_slice = '0;
    for (int unsigned i = 0; i < NIBBLES; i++) begin
      if (idx_q == IW'(i)) begin
        a_slice = a_q[4*i +: 4];
        b_slice = b_q[4*i +: 4];
      end
    end
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    busy      = (state_q != IDLE);
    out_valid = (state_q == DONE);
    add_a     = '0;
    add_b     = '0;
    add_cin   = 1'b0;
    if (state_q == RUN) begin
      add_a   = a_slice;
      add_b   = sub_q ? ~b_slice : b_slice;
      add_cin = carry_q;
    end
    cout   = (state_q == DONE) && carry_q;
    result = res_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      sub_q   <= 1'b0;
      carry_q <= 1'b0;
      idx_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q     <= op_a;
            b_q     <= op_b;
            sub_q   <= op_sub;
            carry_q <= op_sub | op_cin;
            idx_q   <= '0;
          end
        end
        RUN: begin
          for (int unsigned i = 0; i < NIBBLES; i++) begin
            if (idx_q == IW'(i)) res_q[4*i +: 4] <= add_sum;
          end
          carry_q <= add_cout;
          if (idx_q != LAST) idx_q <= idx_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_sequencer.sv
// Scoreboard bench for serial_add_sequencer at NIBBLES=4 and NIBBLES=1,
// with a behavioural 4-bit adder slice attached to each instance.
module tb_serial_add_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  always #5 clk = ~clk;

  logic        in_valid, in_ready, op_cin, op_sub, add_cin, add_cout;
  logic [15:0] op_a, op_b, result;
  logic [3:0]  add_a, add_b, add_sum;
  logic        out_valid, out_ready, cout, busy;

  logic        n1_in_valid, n1_in_ready, n1_op_cin, n1_op_sub, n1_add_cin, n1_add_cout;
  logic [3:0]  n1_op_a, n1_op_b, n1_result, n1_add_a, n1_add_b, n1_add_sum;
  logic        n1_out_valid, n1_out_ready, n1_cout, n1_busy;

  serial_add_sequencer #(.NIBBLES(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op_a(op_a), .op_b(op_b), .op_cin(op_cin), .op_sub(op_sub),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_sum(add_sum), .add_cout(add_cout),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .cout(cout), .busy(busy)
  );

  serial_add_sequencer #(.NIBBLES(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(n1_in_valid), .in_ready(n1_in_ready),
    .op_a(n1_op_a), .op_b(n1_op_b), .op_cin(n1_op_cin), .op_sub(n1_op_sub),
    .add_a(n1_add_a), .add_b(n1_add_b), .add_cin(n1_add_cin),
    .add_sum(n1_add_sum), .add_cout(n1_add_cout),
    .out_valid(n1_out_valid), .out_ready(n1_out_ready),
    .result(n1_result), .cout(n1_cout), .busy(n1_busy)
  );

  assign {add_cout, add_sum}       = {1'b0, add_a} + {1'b0, add_b} + {4'b0, add_cin};
  assign {n1_add_cout, n1_add_sum} = {1'b0, n1_add_a} + {1'b0, n1_add_b} + {4'b0, n1_add_cin};

  typedef struct packed {
    logic [15:0] res;
    logic        c;
  } exp_t;

  exp_t sbq[$];
  exp_t sb1[$];
  int   checks   = 0;
  int   failures = 0;

  function automatic exp_t model(input logic [15:0] a, b, input logic cin, sub);
    exp_t        e;
    logic [16:0] s;
    if (sub) begin
      e.res = a - b;
      e.c   = (a >= b);
    end else begin
      s     = {1'b0, a} + {1'b0, b} + 17'(cin);
      e.res = s[15:0];
      e.c   = s[16];
    end
    return e;
  endfunction

  task automatic run_op(input logic [15:0] a, b, input logic cin, sub,
                        output logic [3:0] cin_seq);
    exp_t e;
    int   cyc;
    sbq.push_back(model(a, b, cin, sub));
    cin_seq = '0;
    @(negedge clk);
    in_valid = 1'b1; op_a = a; op_b = b; op_cin = cin; op_sub = sub;
    @(negedge clk);
    in_valid = 1'b0; op_a = 16'($urandom); op_b = 16'($urandom);
    op_cin = 1'($urandom); op_sub = 1'($urandom);
    cyc = 1;
    while (!out_valid && cyc < 40) begin
      if (cyc <= 4) cin_seq[cyc-1] = add_cin;
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (out_valid !== 1'b1) begin
      failures++;
      $display("FAIL op_timeout: out_valid=%b after %0d cycles, required 1", out_valid, cyc);
      void'(sbq.pop_front());
      return;
    end
    checks++;
    if (cyc - 1 != 4) begin
      failures++;
      $display("FAIL latency: got %0d cycles, required 4", cyc - 1);
    end
    e = sbq.pop_front();
    checks++;
    if (result !== e.res || cout !== e.c) begin
      failures++;
      $display("FAIL result %h op %h sub=%b: got %h/%b, required %h/%b",
               a, b, sub, result, cout, e.res, e.c);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL done_exit: out_valid=%b in_ready=%b, required 0/1", out_valid, in_ready);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b0; op_a = '0; op_b = '0; op_cin = 1'b0; op_sub = 1'b0; out_ready = 1'b1;
    n1_in_valid = 1'b0; n1_op_a = '0; n1_op_b = '0; n1_op_cin = 1'b0; n1_op_sub = 1'b0;
    n1_out_ready = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || result !== 16'h0 || cout !== 1'b0 ||
        add_a !== 4'h0 || add_b !== 4'h0 || add_cin !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: busy=%b ov=%b res=%h cout=%b add=%h/%h/%b, required all 0",
               busy, out_valid, result, cout, add_a, add_b, add_cin);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || n1_in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_ready: in_ready=%b n1=%b, required 1", in_ready, n1_in_ready);
    end
  endtask

  task automatic test_add();
    logic [3:0] seq;
    run_op(16'h1234, 16'h0FFF, 1'b0, 1'b0, seq);
    run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, seq);
    checks++;
    if (seq !== 4'b1110) begin
      failures++;
      $display("FAIL add_cin_seq: got %b (idx3..0), required 1110", seq);
    end
    run_op(16'hABCD, 16'h1111, 1'b1, 1'b0, seq);
  endtask

  task automatic test_sub();
    logic [3:0] seq;
    run_op(16'h0005, 16'h0007, 1'b0, 1'b1, seq);
    checks++;
    if (seq[0] !== 1'b1) begin
      failures++;
      $display("FAIL sub_cin0: got %b, required 1", seq[0]);
    end
    run_op(16'h0007, 16'h0005, 1'b1, 1'b1, seq);
    run_op(16'h0000, 16'h0000, 1'b0, 1'b1, seq);
  endtask

  task automatic test_hold_done();
    exp_t e;
    int   cyc;
    out_ready = 1'b0;
    sbq.push_back(model(16'h8421, 16'h7BDF, 1'b1, 1'b0));
    @(negedge clk);
    in_valid = 1'b1; op_a = 16'h8421; op_b = 16'h7BDF; op_cin = 1'b1; op_sub = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    cyc = 1;
    while (!out_valid && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    e = sbq.pop_front();
    checks++;
    if (out_valid !== 1'b1) begin
      failures++;
      $display("FAIL hold_timeout: out_valid=%b, required 1", out_valid);
    end
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; op_a = 16'h5555; op_b = 16'h3333; op_sub = 1'b1;
      @(negedge clk);
      checks++;
      if (result !== e.res || cout !== e.c || in_ready !== 1'b0 || out_valid !== 1'b1) begin
        failures++;
        $display("FAIL hold_cycle%0d: res=%h cout=%b rdy=%b ov=%b, required %h/%b/0/1",
                 i, result, cout, in_ready, out_valid, e.res, e.c);
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL hold_release: ov=%b rdy=%b busy=%b, required 0/1/0",
               out_valid, in_ready, busy);
    end
  endtask

  task automatic test_reset_mid_run();
    logic [3:0] seq;
    int         pulses;
    @(negedge clk);
    in_valid = 1'b1; op_a = 16'h9999; op_b = 16'h2222; op_cin = 1'b1; op_sub = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1 || result !== 16'h0 ||
        cout !== 1'b0 || add_a !== 4'h0 || add_b !== 4'h0 || add_cin !== 1'b0) begin
      failures++;
      $display("FAIL midrun_reset: busy=%b ov=%b rdy=%b res=%h cout=%b add=%h/%h/%b",
               busy, out_valid, in_ready, result, cout, add_a, add_b, add_cin);
    end
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (out_valid === 1'b1) pulses++;
    end
    checks++;
    if (pulses != 0) begin
      failures++;
      $display("FAIL midrun_no_valid: got %0d pulses, required 0", pulses);
    end
    run_op(16'h1234, 16'h0FFF, 1'b0, 1'b0, seq);
  endtask

  task automatic test_back_to_back();
    logic [3:0] seq;
    for (int i = 0; i < 6; i++)
      run_op(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), seq);
  endtask

  task automatic test_nibbles1();
    logic [3:0] ta[3];
    logic [3:0] tb[3];
    logic       tc[3];
    logic       ts[3];
    exp_t       e;
    int         cyc;
    ta = '{4'hF, 4'h3, 4'h9}; tb = '{4'h1, 4'h5, 4'h2};
    tc = '{1'b1, 1'b0, 1'b0}; ts = '{1'b0, 1'b1, 1'b1};
    for (int k = 0; k < 3; k++) begin
      e = model({12'h0, ta[k]}, {12'h0, tb[k]}, tc[k], ts[k]);
      if (!ts[k]) e.c = e.res[4];
      e.res = {12'h0, e.res[3:0]};
      sb1.push_back(e);
      @(negedge clk);
      n1_in_valid = 1'b1; n1_op_a = ta[k]; n1_op_b = tb[k]; n1_op_cin = tc[k]; n1_op_sub = ts[k];
      @(negedge clk);
      n1_in_valid = 1'b0;
      checks++;
      if (n1_add_a !== ta[k] || n1_add_cin !== (ts[k] | tc[k]) || n1_busy !== 1'b1) begin
        failures++;
        $display("FAIL n1_run%0d: add_a=%h cin=%b busy=%b, required %h/%b/1",
                 k, n1_add_a, n1_add_cin, n1_busy, ta[k], ts[k] | tc[k]);
      end
      cyc = 1;
      while (!n1_out_valid && cyc < 20) begin
        @(negedge clk);
        cyc++;
      end
      e = sb1.pop_front();
      checks++;
      if (n1_out_valid !== 1'b1 || cyc - 1 != 1 || n1_result !== e.res[3:0] || n1_cout !== e.c) begin
        failures++;
        $display("FAIL n1_result%0d: ov=%b lat=%0d res=%h cout=%b, required 1/1/%h/%b",
                 k, n1_out_valid, cyc - 1, n1_result, n1_cout, e.res[3:0], e.c);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_hold_done();
    test_reset_mid_run();
    test_back_to_back();
    test_nibbles1();
    checks++;
    if (sbq.size() != 0 || sb1.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: %0d/%0d entries left, required 0", sbq.size(), sb1.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: bench exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
